// File: rtl/ct_spsram_pkg.sv
// Shared widths, FIFO depth and FSM state encoding for the 128x16 single-port SRAM controller.
package ct_spsram_pkg;

    localparam int ADDR_WIDTH     = 7;
    localparam int DATA_WIDTH     = 16;
    localparam int RSP_FIFO_DEPTH = 2;
    localparam int CNT_WIDTH      = $clog2(RSP_FIFO_DEPTH + 1);
    localparam int PTR_WIDTH      = (RSP_FIFO_DEPTH > 1) ? $clog2(RSP_FIFO_DEPTH) : 1;

    typedef enum logic {
        ST_INIT = 1'b0,
        ST_IDLE = 1'b1
    } ctrl_state_e;

endpackage

// File: rtl/ct_spsram_rsp_fifo.sv
// In-order read-response FIFO; push and pop may happen in the same cycle.
module ct_spsram_rsp_fifo
    import ct_spsram_pkg::*;
(
    input  logic                  CLK,
    input  logic                  RST,
    input  logic                  push,
    input  logic [DATA_WIDTH-1:0] push_data,
    input  logic                  pop,
    output logic [DATA_WIDTH-1:0] head_data,
    output logic [CNT_WIDTH-1:0]  count
);

    logic [DATA_WIDTH-1:0] mem [RSP_FIFO_DEPTH];
    logic [PTR_WIDTH-1:0]  wr_ptr;
    logic [PTR_WIDTH-1:0]  rd_ptr;
    logic                  full;
    logic                  pop_ok;
    logic                  push_ok;

    assign full      = (count == CNT_WIDTH'(RSP_FIFO_DEPTH));
    assign pop_ok    = pop & (count != '0);
    assign push_ok   = push & (~full | pop_ok);
    assign head_data = mem[rd_ptr];

    // Pointers wrap naturally because the depth is a power of two.
    always_ff @(posedge CLK) begin
        if (RST) begin
            count  <= '0;
            wr_ptr <= '0;
            rd_ptr <= '0;
            for (int i = 0; i < RSP_FIFO_DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else begin
            if (push_ok) begin
                mem[wr_ptr] <= push_data;
                wr_ptr      <= wr_ptr + 1'b1;
            end
            if (pop_ok) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            count <= count + CNT_WIDTH'(push_ok) - CNT_WIDTH'(pop_ok);
        end
    end

    always @(posedge CLK) begin
        if (!RST) begin
            assert (!(push && full && !pop_ok));
        end
    end

endmodule

// File: rtl/ct_f_spsram_128x16_ctrl.sv
// Request/response controller for a 128x16 single-port SRAM with bit-masked writes.
// Define CT_SPSRAM_INIT_EN to zero-fill the whole array after every reset.
module ct_f_spsram_128x16_ctrl
    import ct_spsram_pkg::*;
(
    input  logic                  CLK,
    input  logic                  RST,
    input  logic                  req_vld,
    output logic                  req_rdy,
    input  logic                  req_wr,
    input  logic [ADDR_WIDTH-1:0] req_addr,
    input  logic [DATA_WIDTH-1:0] req_wdata,
    input  logic [DATA_WIDTH-1:0] req_bmask,
    output logic [ADDR_WIDTH-1:0] sram_a,
    output logic                  sram_cen,
    output logic                  sram_gwen,
    output logic [DATA_WIDTH-1:0] sram_wen,
    output logic [DATA_WIDTH-1:0] sram_d,
    input  logic [DATA_WIDTH-1:0] sram_q,
    output logic                  rsp_vld,
    input  logic                  rsp_rdy,
    output logic [DATA_WIDTH-1:0] rsp_rdata,
    output logic                  init_done,
    output ctrl_state_e           state_dbg
);

    ctrl_state_e            state;
    logic                   rd_inflight;
    logic [CNT_WIDTH-1:0]   fifo_count;
    logic [CNT_WIDTH:0]     rd_used;
    logic                   rd_room;
    logic                   rsp_pop;
    logic                   req_acc;
    logic                   init_wr;
    logic [ADDR_WIDTH-1:0]  init_addr;

`ifdef CT_SPSRAM_INIT_EN
    logic [ADDR_WIDTH-1:0] init_cnt;

    // The counter holds at the last address; the state change alone ends the fill.
    always_ff @(posedge CLK) begin
        if (RST) begin
            state     <= ST_INIT;
            init_cnt  <= '0;
            init_done <= 1'b0;
        end else if (state == ST_INIT) begin
            if (init_cnt == '1) begin
                state     <= ST_IDLE;
                init_done <= 1'b1;
            end else begin
                init_cnt <= init_cnt + 1'b1;
            end
        end
    end

    assign init_wr   = (state == ST_INIT) & ~RST;
    assign init_addr = init_cnt;
`else
    assign state     = ST_IDLE;
    assign init_done = 1'b1;
    assign init_wr   = 1'b0;
    assign init_addr = '0;
`endif

    assign state_dbg = state;
    assign rsp_vld   = (fifo_count != '0);
    assign rsp_pop   = rsp_vld & rsp_rdy;

    // Slots already promised to reads, with a same-cycle pop counted as freed.
    assign rd_used = (CNT_WIDTH+1)'(fifo_count) + (CNT_WIDTH+1)'(rd_inflight)
                   - (CNT_WIDTH+1)'(rsp_pop);
    assign rd_room = (rd_used < (CNT_WIDTH+1)'(RSP_FIFO_DEPTH));
    assign req_rdy = (state == ST_IDLE) & ~RST & (req_wr | rd_room);
    assign req_acc = req_vld & req_rdy;

    always_ff @(posedge CLK) begin
        if (RST) begin
            rd_inflight <= 1'b0;
        end else begin
            rd_inflight <= req_acc & ~req_wr;
        end
    end

    always_comb begin
        sram_a    = '0;
        sram_cen  = 1'b1;
        sram_gwen = 1'b1;
        sram_wen  = '1;
        sram_d    = '0;
        if (init_wr) begin
            sram_a    = init_addr;
            sram_cen  = 1'b0;
            sram_gwen = 1'b0;
            sram_wen  = '0;
        end else if (req_acc) begin
            sram_a   = req_addr;
            sram_cen = 1'b0;
            if (req_wr) begin
                sram_gwen = 1'b0;
                sram_wen  = ~req_bmask;
                sram_d    = req_wdata;
            end
        end
    end

    ct_spsram_rsp_fifo u_rsp_fifo (
        .CLK       (CLK),
        .RST       (RST),
        .push      (rd_inflight),
        .push_data (sram_q),
        .pop       (rsp_pop),
        .head_data (rsp_rdata),
        .count     (fifo_count)
    );

endmodule
